// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Drains an upstream synchronous FIFO in bursts and presents the words as a
//   valid/ready stream with a last-beat marker.
//
//   Ports
//     clk_i, rst_n_i   : clock, asynchronous active-low reset
//     fifo_rdata_i     : FIFO read data, valid the cycle after fifo_rd_en_o
//     fifo_rd_en_o     : FIFO read enable
//     fifo_empty_i     : FIFO empty flag
//     fifo_elements_i  : FIFO occupancy
//     m_data_o/m_valid_o/m_ready_i/m_last_o : output stream
//     busy_o           : high while the FSM is in BURST (mirrors the FSM state)
//     burst_cnt_o      : number of completed bursts, wraps at 16 bits
//
//   Handshake: a beat transfers on a rising clk_i edge where m_valid_o and
//   m_ready_i are both high. Once m_valid_o is high, m_data_o and m_last_o
//   hold until the beat transfers.
//
//   Optional feature (macro FIFO_BURST_READER_TIMEOUT_EN): a partial burst of
//   the words currently in the FIFO is flushed after TIMEOUT idle cycles.
//   Without the macro only full BURST_LEN bursts are issued.
module fifo_burst_reader #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int ELS_SIZE  = $clog2(DEPTH),
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [WIDTH-1:0]    fifo_rdata_i,
  output logic                fifo_rd_en_o,
  input  logic                fifo_empty_i,
  input  logic [ELS_SIZE:0]   fifo_elements_i,
  output logic [WIDTH-1:0]    m_data_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic                m_last_o,
  output logic                busy_o,
  output logic [15:0]         burst_cnt_o
);

  localparam int CW = ELS_SIZE + 1;
  localparam logic [CW-1:0] BURST_LEN_C = CW'(BURST_LEN);

  if (BURST_LEN < 1 || BURST_LEN > DEPTH) begin : g_bad_burst_len
    $error("fifo_burst_reader: BURST_LEN must be in 1..DEPTH");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fifo_burst_reader: TIMEOUT must be at least 1");
  end

  typedef enum logic {IDLE, BURST} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     issued_q;     // reads issued in this burst
  logic [CW-1:0]     beats_q;      // beats transferred in this burst
  logic              inflight_q;   // read issued last cycle, data arrives now
  logic [WIDTH-1:0]  buf_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        cnt_q;        // output buffer occupancy
  logic [15:0]       burst_cnt_q;
  logic              pop, done;
  logic [2:0]        occ;

  assign m_valid_o   = (cnt_q != 2'd0);
  assign m_data_o    = buf_q[rd_ptr_q];
  assign m_last_o    = m_valid_o && (beats_q == len_q - CW'(1));
  assign pop         = m_valid_o && m_ready_i;
  assign done        = pop && m_last_o;
  assign busy_o      = (state_q == BURST);
  assign burst_cnt_o = burst_cnt_q;

  // Occupancy counts the beat leaving this cycle as already gone, so a new
  // read can be issued in the same cycle a beat drains. This keeps one beat
  // per cycle with m_ready_i high while never holding more than two words
  // between buffer and in-flight read.
  assign occ = 3'(cnt_q) - 3'(pop) + 3'(inflight_q);

  assign fifo_rd_en_o = (state_q == BURST) && (issued_q < len_q) &&
                        !fifo_empty_i && (occ < 3'd2);

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  logic          partial, tmo_hit;

  assign partial = (state_q == IDLE) && (fifo_elements_i != '0) &&
                   (fifo_elements_i < BURST_LEN_C);
  assign tmo_hit = partial && (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_q <= '0;
    end else if (!partial || tmo_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TW'(1);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (fifo_elements_i >= BURST_LEN_C) begin
          state_d = BURST;
          len_d   = BURST_LEN_C;
        end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = BURST;
          len_d   = fifo_elements_i;
        end
`endif
      end
      BURST: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      beats_q     <= '0;
      inflight_q  <= 1'b0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      burst_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      inflight_q <= fifo_rd_en_o;
      if (fifo_rd_en_o) begin
        issued_q <= issued_q + CW'(1);
      end
      // Only the cycle after an accepted read carries valid FIFO data.
      if (inflight_q) begin
        buf_q[wr_ptr_q] <= fifo_rdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        beats_q  <= beats_q + CW'(1);
      end
      case ({inflight_q, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
      // On the last beat every read has been issued and consumed, so the
      // buffer is empty and both pointers are equal again.
      if (done) begin
        issued_q    <= '0;
        beats_q     <= '0;
        burst_cnt_q <= burst_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader
//   Bench for fifo_burst_reader with default parameters (WIDTH 32, DEPTH 16,
//   BURST_LEN 4, TIMEOUT 64). A behavioural FIFO feeds the DUT; expected
//   beats {last, data} are queued when words are written and compared as the
//   DUT transfers them. Build with +define+FIFO_BURST_READER_TIMEOUT_EN to
//   exercise the partial-burst flush.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fifo_rdata;
  logic        fifo_rd_en;
  logic        fifo_empty;
  logic [4:0]  fifo_elements;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic [15:0] burst_cnt;

  // driver-side signals
  logic        wr_en;
  logic [31:0] wr_data;
  logic        force_empty;

  // behavioural FIFO
  logic [31:0] mem[$];
  int          fcnt;

  // scoreboard and monitor state
  logic [32:0] exp_q[$];
  int          beat_cyc[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          reads = 0;
  int          beats = 0;
  int          max_out = 0;
  int          viol = 0;
  int          busy_rise = 0;
  logic        busy_prev = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] hold_data = '0;
  logic        hold_last = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  fifo_burst_reader dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .fifo_rdata_i    (fifo_rdata),
    .fifo_rd_en_o    (fifo_rd_en),
    .fifo_empty_i    (fifo_empty),
    .fifo_elements_i (fifo_elements),
    .m_data_o        (m_data),
    .m_valid_o       (m_valid),
    .m_ready_i       (m_ready),
    .m_last_o        (m_last),
    .busy_o          (busy),
    .burst_cnt_o     (burst_cnt)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem.delete();
      fcnt       <= 0;
      fifo_rdata <= '0;
    end else begin
      if (fifo_rd_en && mem.size() > 0) fifo_rdata <= mem.pop_front();
      if (wr_en) mem.push_back(wr_data);
      fcnt <= mem.size();
    end
  end

  assign fifo_empty    = (fcnt == 0) || force_empty;
  assign fifo_elements = fcnt[4:0];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Sampled half a cycle before the next rising edge: what is seen here is
  // exactly what that edge acts on.
  task automatic sample();
    cyc++;
    if (!rst_n) begin
      reads = 0; beats = 0; stall_prev = 1'b0; busy_prev = 1'b0;
    end else begin
      if (fifo_rd_en && fifo_empty) viol++;
      if (fifo_rd_en) reads++;
      if (busy && !busy_prev) busy_rise = cyc;
      busy_prev = busy;
      if (stall_prev) begin
        check("hold_valid", 64'(m_valid), 64'(1));
        check("hold_data", 64'(m_data), 64'(hold_data));
        check("hold_last", 64'(m_last), 64'(hold_last));
      end
      stall_prev = m_valid && !m_ready;
      hold_data  = m_data;
      hold_last  = m_last;
      if (m_valid && m_ready) begin
        beats++;
        beat_cyc.push_back(cyc);
        check("beat_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) check("beat", 64'({m_last, m_data}), 64'(exp_q.pop_front()));
      end
      if (reads - beats > max_out) max_out = reads - beats;
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    sample();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic write_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 32'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic expect_words(input logic [31:0] base, input int n, input int burst);
    for (int i = 0; i < n; i++) begin
      logic l;
      l = ((i + 1) % burst == 0);
      exp_q.push_back({l, base + 32'(i)});
    end
  endtask

  task automatic drain(input string tag, input int budget, input bit toggle);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      if (toggle) m_ready = (k % 3 == 0);
      step();
      k++;
    end
    m_ready = 1'b1;
    check(tag, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, 64'(fifo_rd_en), 64'(0));
    check({tag, "_valid"}, 64'(m_valid), 64'(0));
    check({tag, "_data"}, 64'(m_data), 64'(0));
    check({tag, "_last"}, 64'(m_last), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_bcnt"}, 64'(burst_cnt), 64'(0));
  endtask

  initial begin
    int k, b0, r0;
    rst_n = 1'b0; m_ready = 1'b1; wr_en = 1'b0; wr_data = '0; force_empty = 1'b0;
    repeat (3) step();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    step();

    // single full burst, latency and back-to-back beats
    beat_cyc.delete();
    expect_words(32'h1, 4, 4);
    write_words(32'h1, 4);
    drain("t1_drain", 40, 1'b0);
    check("t1_bcnt", 64'(burst_cnt), 64'(1));
    check("t1_nbeats", 64'(beat_cyc.size()), 64'(4));
    if (beat_cyc.size() == 4) begin
      check("t1_consec", 64'(beat_cyc[3] - beat_cyc[0]), 64'(3));
      check("t1_latency", 64'(beat_cyc[0] - busy_rise), 64'(2));
    end

    // two bursts back-to-back
    expect_words(32'h10, 8, 4);
    write_words(32'h10, 8);
    drain("t2_drain", 60, 1'b0);
    check("t2_bcnt", 64'(burst_cnt), 64'(3));
    check("t2_busy", 64'(busy), 64'(0));

    // stream stalls with ready pattern 1,0,0,...
    expect_words(32'h20, 4, 4);
    write_words(32'h20, 4);
    drain("t3_drain", 60, 1'b1);
    check("t3_bcnt", 64'(burst_cnt), 64'(4));

    // FIFO empty forced mid-burst
    expect_words(32'h30, 4, 4);
    m_ready = 1'b0;
    write_words(32'h30, 4);
    k = 0;
    while (!busy && k < 20) begin step(); k++; end
    check("t5_busy", 64'(busy), 64'(1));
    repeat (4) step();
    force_empty = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_rd_en_held", 64'(fifo_rd_en), 64'(0));
    end
    force_empty = 1'b0;
    drain("t5_drain", 40, 1'b0);
    check("t5_bcnt", 64'(burst_cnt), 64'(5));

    // partial burst
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    expect_words(32'h40, 3, 3);
    write_words(32'h40, 3);
    b0 = beats;
    repeat (50) step();
    check("t6_no_early", 64'(beats - b0), 64'(0));
    drain("t6_drain", 100, 1'b0);
`else
    write_words(32'h40, 3);
    b0 = beats;
    r0 = busy_rise;
    repeat (200) step();
    check("t6_no_beats", 64'(beats - b0), 64'(0));
    check("t6_no_burst", 64'(busy_rise), 64'(r0));
    expect_words(32'h40, 4, 4);
    write_words(32'h43, 1);
    drain("t6_drain", 40, 1'b0);
`endif
    check("t6_bcnt", 64'(burst_cnt), 64'(6));

    // reset after the second beat of a burst
    expect_words(32'h50, 4, 4);
    write_words(32'h50, 4);
    b0 = beats;
    k = 0;
    while (beats - b0 < 2 && k < 30) begin step(); k++; end
    check("t7_two_beats", 64'(beats - b0), 64'(2));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t7");
    exp_q.delete();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (20) step();
    check("t7_no_beats", 64'(beats), 64'(0));
    check("t7_idle", 64'(busy), 64'(0));

    // recovery after reset
    expect_words(32'h60, 4, 4);
    write_words(32'h60, 4);
    drain("t8_drain", 40, 1'b0);
    check("t8_bcnt", 64'(burst_cnt), 64'(1));

    check("rd_while_empty", 64'(viol), 64'(0));
    check("outstanding_le2", 64'(max_out <= 2), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width; equals the upstream FIFO WIDTH.
REQ-002 SHALL have parameter DEPTH, default 16, upstream FIFO depth.
REQ-003 SHALL have parameter ELS_SIZE, default $clog2(DEPTH), FIFO occupancy index width.
REQ-004 SHALL have parameter BURST_LEN, default 4, beats per full burst; legal range 1..DEPTH.
REQ-005 SHALL have parameter TIMEOUT, default 64, idle cycles before a partial-burst flush; minimum 1.
REQ-006 SHALL have port clk_i  input  1  single clock for all logic.
REQ-007 SHALL have port rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port fifo_rdata_i  input  WIDTH  FIFO read data, valid the cycle after an accepted read.
REQ-009 SHALL have port fifo_rd_en_o  output  1  FIFO read enable.
REQ-010 SHALL have port fifo_empty_i  input  1  FIFO empty flag.
REQ-011 SHALL have port fifo_elements_i  input  ELS_SIZE+1  FIFO occupancy.
REQ-012 SHALL have port m_data_o  output  WIDTH  stream data.
REQ-013 SHALL have port m_valid_o  output  1  stream valid.
REQ-014 SHALL have port m_ready_i  input  1  stream ready.
REQ-015 SHALL have port m_last_o  output  1  final beat of burst, qualified by m_valid_o.
REQ-016 SHALL have port busy_o  output  1  high while state is BURST.
REQ-017 SHALL have port burst_cnt_o  output  16  completed-burst count, wraps 0xFFFF->0.

Function
REQ-018 SHALL implement FSM with states IDLE and BURST; busy_o = (state == BURST).
REQ-019 SHALL transition IDLE->BURST when fifo_elements_i >= BURST_LEN, latching burst length len = BURST_LEN.
REQ-020 SHALL drive fifo_rd_en_o = BURST && issued < len && !fifo_empty_i && (buffer occupancy + reads in flight) < 2.
REQ-021 SHALL capture fifo_rdata_i one cycle after each asserted fifo_rd_en_o into a 2-entry output buffer; data from no other cycle is captured.
REQ-022 SHALL present the buffer head on m_data_o/m_valid_o; a beat transfers on m_valid_o && m_ready_i.
REQ-023 SHALL hold m_data_o and m_last_o stable while m_valid_o && !m_ready_i.
REQ-024 SHALL sustain one beat per cycle with m_ready_i held high after pipeline fill.
REQ-025 SHALL give latency: state enters BURST at edge T0, fifo_rd_en_o high during cycle T0..T1, m_valid_o high after edge T2.
REQ-026 SHALL assert m_last_o only on beat number len of the burst.
REQ-027 SHALL return to IDLE and increment burst_cnt_o on the edge the last beat transfers.
REQ-028 SHALL re-evaluate the IDLE->BURST condition in the cycle immediately after the return to IDLE (back-to-back bursts allowed).
REQ-029 SHALL never read while fifo_empty_i is high; a stalled read resumes when fifo_empty_i drops.

Reset
REQ-030 SHALL on rst_n_i low, asynchronously: state IDLE, fifo_rd_en_o 0, m_valid_o 0, m_data_o 0, m_last_o 0, busy_o 0, burst_cnt_o 0, buffer and in-flight counters 0, timeout counter 0.
REQ-031 SHALL discard buffered and in-flight data when reset asserts mid-burst; no partial burst completes after release.

Configuration
REQ-032 SHALL support macro FIFO_BURST_READER_TIMEOUT_EN.
REQ-033 With FIFO_BURST_READER_TIMEOUT_EN defined: in IDLE with 0 < fifo_elements_i < BURST_LEN, a counter increments each cycle, clears when fifo_elements_i is 0 or >= BURST_LEN, and on reaching TIMEOUT enters BURST with len = fifo_elements_i.
REQ-034 Without FIFO_BURST_READER_TIMEOUT_EN: no timeout counter is built; only full BURST_LEN bursts are issued, and partial data stays in the FIFO indefinitely.

Verification
REQ-035 Write 4 words 0x1..0x4, m_ready_i=1 -> beats 0x1..0x4 on 4 consecutive cycles, m_last_o on 0x4, burst_cnt_o=1.
REQ-036 Write 8 words, m_ready_i=1 -> two bursts back-to-back, m_last_o on beats 4 and 8, burst_cnt_o=2.
REQ-037 Burst of 4 with m_ready_i toggling 1,0,0,1,... -> no loss or duplication, data held stable while stalled, never more than 2 reads outstanding.
REQ-038 Macro defined, TIMEOUT=64, write 3 words -> burst of 3 starts 64 cycles later, m_last_o on third beat; macro undefined -> no output after 200 cycles.
REQ-039 rst_n_i pulsed low after second beat of a 4-beat burst -> all outputs 0 immediately, busy_o 0, burst_cnt_o 0.
REQ-040 fifo_empty_i forced high mid-burst for 5 cycles -> fifo_rd_en_o 0 throughout, burst resumes and completes with correct data.
